// File: rtl/reg_file_pkg.sv
// +----------------------------------------------------------------------+
// | reg_file_pkg : shared sizes and reset constants for the register file |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_file_pkg;
  localparam int                     DataSize     = 32;
  localparam int                     RegAddrSize  = 5;
  localparam int                     RegNum       = 2 ** RegAddrSize;
  localparam logic [DataSize-1:0]    DataBusReset = '0;
  localparam logic [RegAddrSize-1:0] RegAddrReset = '0;
  localparam logic [RegAddrSize-1:0] ZeroRegAddr  = '0;
endpackage

`default_nettype wire

// File: rtl/reg_file_if.sv
// +----------------------------------------------------------------------+
// | reg_file_if : write-back and dual read-port bundle of the register   |
// | file; master is the pipeline side, slave is reg_file.                |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DataWidth    = DataSize,
  parameter int RegAddrWidth = RegAddrSize
) ();
  logic                    writeEnableIn;
  logic [RegAddrWidth-1:0] writeBackAddrIn;
  logic [DataWidth-1:0]    dataToRegIn;
  logic                    readEnable1;
  logic [RegAddrWidth-1:0] readAddr1;
  logic                    readEnable2;
  logic [RegAddrWidth-1:0] readAddr2;
  logic                    stall;
  logic [DataWidth-1:0]    readData1;
  logic [DataWidth-1:0]    readData2;

  modport master (
    output writeEnableIn, writeBackAddrIn, dataToRegIn,
    output readEnable1, readAddr1, readEnable2, readAddr2, stall,
    input  readData1, readData2
  );

  modport slave (
    input  writeEnableIn, writeBackAddrIn, dataToRegIn,
    input  readEnable1, readAddr1, readEnable2, readAddr2, stall,
    output readData1, readData2
  );
endinterface

`default_nettype wire

// File: rtl/reg_read_port.sv
// +----------------------------------------------------------------------+
// | reg_read_port : one registered read port with x0 forcing, write-first |
// | bypass, enable gating and stall hold.                                 |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int DataWidth    = DataSize,
  parameter int RegAddrWidth = RegAddrSize
) (
  input  wire logic                    clk,
  input  wire logic                    resetIn,
  input  wire logic                    readEnable,
  input  wire logic [RegAddrWidth-1:0] readAddr,
  input  wire logic [DataWidth-1:0]    storedData,
  input  wire logic                    writeEnable,
  input  wire logic [RegAddrWidth-1:0] writeAddr,
  input  wire logic [DataWidth-1:0]    writeData,
  input  wire logic                    stall,
  output logic      [DataWidth-1:0]    readData
);
  localparam logic [DataWidth-1:0]    c_DATA_RST = DataWidth'(DataBusReset);
  localparam logic [RegAddrWidth-1:0] c_ZERO_IDX = RegAddrWidth'(ZeroRegAddr);

  logic                 w_is_zero;
  logic                 w_bypass;
  logic [DataWidth-1:0] w_next;

  assign w_is_zero = (readAddr == c_ZERO_IDX);
  // A write landing on the same index this cycle wins over the stored copy.
  assign w_bypass  = writeEnable && (writeAddr == readAddr);

  always_comb begin
    w_next = c_DATA_RST;
    if (readEnable && !w_is_zero)
      w_next = w_bypass ? writeData : storedData;
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn)
      readData <= c_DATA_RST;
    else if (!stall)
      readData <= w_next;
  end
endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// +----------------------------------------------------------------------+
// | reg_file : 2**RegAddrWidth x DataWidth register file, one write port, |
// | two synchronous read ports, x0 hardwired to zero.                     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file
  import reg_file_pkg::*;
#(
  parameter int DataWidth    = DataSize,
  parameter int RegAddrWidth = RegAddrSize
) (
  input  wire logic clk,
  input  wire logic resetIn,
  reg_file_if.slave bus
);
  localparam int                      c_REG_NUM  = (RegAddrWidth == RegAddrSize) ? RegNum
                                                                                 : 2 ** RegAddrWidth;
  localparam logic [DataWidth-1:0]    c_DATA_RST = DataWidth'(DataBusReset);
  localparam logic [RegAddrWidth-1:0] c_ZERO_IDX = RegAddrWidth'(ZeroRegAddr);

  logic [DataWidth-1:0] r_regs [c_REG_NUM];
  logic [DataWidth-1:0] w_stored1;
  logic [DataWidth-1:0] w_stored2;
  logic                 w_wr_en;

  // Index 0 is never written, so it stays at its reset value of zero.
  assign w_wr_en = bus.writeEnableIn && (bus.writeBackAddrIn != c_ZERO_IDX);

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      for (int i = 0; i < c_REG_NUM; i++)
        r_regs[i] <= c_DATA_RST;
    end else if (w_wr_en) begin
      r_regs[bus.writeBackAddrIn] <= bus.dataToRegIn;
    end
  end

  assign w_stored1 = r_regs[bus.readAddr1];
  assign w_stored2 = r_regs[bus.readAddr2];

  reg_read_port #(
    .DataWidth    (DataWidth),
    .RegAddrWidth (RegAddrWidth)
  ) u_read_port1 (
    .clk         (clk),
    .resetIn     (resetIn),
    .readEnable  (bus.readEnable1),
    .readAddr    (bus.readAddr1),
    .storedData  (w_stored1),
    .writeEnable (bus.writeEnableIn),
    .writeAddr   (bus.writeBackAddrIn),
    .writeData   (bus.dataToRegIn),
    .stall       (bus.stall),
    .readData    (bus.readData1)
  );

  reg_read_port #(
    .DataWidth    (DataWidth),
    .RegAddrWidth (RegAddrWidth)
  ) u_read_port2 (
    .clk         (clk),
    .resetIn     (resetIn),
    .readEnable  (bus.readEnable2),
    .readAddr    (bus.readAddr2),
    .storedData  (w_stored2),
    .writeEnable (bus.writeEnableIn),
    .writeAddr   (bus.writeBackAddrIn),
    .writeData   (bus.dataToRegIn),
    .stall       (bus.stall),
    .readData    (bus.readData2)
  );
endmodule

`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DataWidth, 32, width of every architectural register and data port.
REQ-002 Parameter RegAddrWidth, 5, register index width; register count is 2**RegAddrWidth.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetIn  input  1  asynchronous, active-low reset.
REQ-005 writeEnableIn  input  1  write-back request from MEM/WB stage.
REQ-006 writeBackAddrIn  input  RegAddrWidth  destination register index.
REQ-007 dataToRegIn  input  DataWidth  write-back data.
REQ-008 readEnable1  input  1  port-1 read request from decode.
REQ-009 readAddr1  input  RegAddrWidth  port-1 source index.
REQ-010 readEnable2  input  1  port-2 read request from decode.
REQ-011 readAddr2  input  RegAddrWidth  port-2 source index.
REQ-012 stall  input  1  decode stall; freezes read outputs.
REQ-013 readData1  output  DataWidth  registered port-1 operand.
REQ-014 readData2  output  DataWidth  registered port-2 operand.

Function
REQ-015 Storage SHALL be 2**RegAddrWidth registers of DataWidth bits; register 0 SHALL always read zero.
REQ-016 On a rising edge with writeEnableIn=1 and writeBackAddrIn!=0, the addressed register SHALL take dataToRegIn; writes to index 0 SHALL be discarded.
REQ-017 Reads SHALL be synchronous, latency 1: readDataN updates on the edge after readEnableN/readAddrN are presented.
REQ-018 With stall=0 and readEnableN=0, readDataN SHALL load zero on the next edge.
REQ-019 With stall=0, readEnableN=1, readAddrN=0, readDataN SHALL load zero regardless of any same-cycle write to index 0.
REQ-020 Write-first bypass: with stall=0, readEnableN=1, readAddrN!=0, and a same-cycle write to readAddrN, readDataN SHALL load dataToRegIn, not the old register value.
REQ-021 Otherwise, with stall=0 and readEnableN=1, readDataN SHALL load the stored value of readAddrN.
REQ-022 With stall=1, readData1 and readData2 SHALL hold their current values; register writes SHALL still occur.
REQ-023 Held values are not refreshed by writes landing during stall; decode re-issues the read after stall deasserts to obtain new data.
REQ-024 Both ports SHALL be independent; both reading the same index, including under bypass, SHALL return identical data.
REQ-025 No X SHALL propagate to readDataN while resetIn=1, regardless of prior access history.

Reset
REQ-026 While resetIn=0, all registers, readData1 and readData2 SHALL be zero, asynchronously to clk.
REQ-027 Writes presented while resetIn=0 SHALL be lost; the first write captured is on the first rising edge with resetIn=1.
REQ-028 Reset asserted mid-stall SHALL clear held outputs; after release, outputs follow REQ-017..022 normally.

Structure
REQ-029 Shared define file SHALL hold DataSize, RegAddrSize, DataBusReset (zero), RegAddrReset (zero), RegNum and ZeroRegAddr; reg_file SHALL use these, not literals.
REQ-030 Read logic (zero-check, bypass compare, enable gating, stall hold, output register) SHALL be one sub-module reg_read_port, instantiated twice.
REQ-031 Storage and write logic SHALL reside in reg_file only.

Verification
REQ-032 Reset: drive resetIn=0 mid-cycle after writing x5=0x1234 -> readData1/2 go to 0 immediately; after release, read x5 -> 0x00000000.
REQ-033 Write/read: write x7=0xDEADBEEF, next cycle read port1 x7 -> readData1=0xDEADBEEF one edge later; port2 disabled -> readData2=0.
REQ-034 Bypass: x3 holds 0x11; same cycle write x3=0x22 and read x3 on both ports -> readData1=readData2=0x22.
REQ-035 Zero register: write x0=0xFFFFFFFF while reading x0 on port1 -> readData1=0; later read x0 -> 0.
REQ-036 Stall: read x9=0xA5A5A5A5, assert stall two cycles while writing x9=0x5A5A5A5A and changing readAddr1 -> readData1 stays 0xA5A5A5A5; deassert and re-read -> 0x5A5A5A5A.
